// File: rtl/psum_reader_pkg.sv
// Shared constants and types for the psum readback path.
// Imported by the row FIFO and the column serializer.
package psum_reader_pkg;

    localparam int COL     = 8;
    localparam int BW      = 8;
    localparam int BW_PSUM = 2 * BW + 4;
    localparam int COL_W   = $clog2(COL);
    localparam int DEPTH   = 4;

    typedef logic [BW_PSUM-1:0]     psum_word_t;
    typedef logic [BW_PSUM*COL-1:0] psum_row_t;

    typedef enum logic {
        IDLE,
        STREAM
    } rd_state_t;

endpackage

// File: rtl/psum_row_fifo.sv
// Row-wide FIFO holding captured psum rows until they are serialized.
// Push is refused when full, even if a pop happens on the same edge.
module psum_row_fifo
    import psum_reader_pkg::*;
#(
    parameter int depth = DEPTH,
    parameter int PW    = $clog2(depth),
    parameter int CW    = PW + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push,
    input  psum_row_t       push_row,
    input  logic            pop,
    output psum_row_t       head,
    output logic            full,
    output logic            empty,
    output logic [CW-1:0]   count
);

    localparam logic [CW-1:0] FULL_CNT = CW'(depth);

    psum_row_t     mem [depth];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push && !reset) begin
            mem[wr_ptr] <= push_row;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/psum_reader.sv
// Captures psum rows from the core output bus and streams them
// downstream one column word at a time over valid/ready.
module psum_reader
    import psum_reader_pkg::*;
#(
    parameter int depth = DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [BW_PSUM*COL-1:0]   psum_in,
    input  logic                     psum_valid,
    output logic                     psum_full,
    output logic [BW_PSUM-1:0]       rd_data,
    output logic [COL_W-1:0]         rd_col,
    output logic                     rd_last,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [15:0]              row_cnt,
    output logic                     overflow
);

    localparam int CW = $clog2(depth) + 1;
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(COL - 1);

    rd_state_t        state;
    logic [COL_W-1:0] col_idx;
    psum_row_t        head;
    psum_word_t       words [COL];
    logic             full;
    logic             empty;
    logic [CW-1:0]    count;
    logic             push_ok;
    logic             xfer;
    logic             at_last;
    logic             pop;

    psum_row_fifo #(.depth(depth)) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (psum_valid),
        .push_row (psum_in),
        .pop      (pop),
        .head     (head),
        .full     (full),
        .empty    (empty),
        .count    (count)
    );

    always_comb begin
        for (int c = 0; c < COL; c++) begin
            words[c] = head[c*BW_PSUM +: BW_PSUM];
        end
    end

    assign push_ok  = psum_valid && !full;
    assign rd_valid = (state == STREAM);
    assign at_last  = (col_idx == LAST_COL);
    assign xfer     = rd_valid && rd_ready;
    assign pop      = xfer && at_last;

    assign psum_full = full;
    assign rd_col    = col_idx;
    assign rd_last   = rd_valid && at_last;
    assign rd_data   = rd_valid ? words[col_idx] : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            col_idx  <= '0;
            row_cnt  <= '0;
            overflow <= 1'b0;
        end else begin
            if (psum_valid && full) begin
                overflow <= 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (push_ok) begin
                        state <= STREAM;
                    end
                end
                STREAM: begin
                    if (xfer && at_last) begin
                        col_idx <= '0;
                        row_cnt <= row_cnt + 16'd1;
                        // last buffered row leaving with nothing arriving
                        if (count == CW'(1) && !push_ok) begin
                            state <= IDLE;
                        end
                    end else if (xfer) begin
                        col_idx <= col_idx + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic unused_empty;
    assign unused_empty = empty;

endmodule

// File: tb/tb_psum_reader.sv
// Randomized and directed bench for psum_reader, checked each cycle
// against a queue-of-rows reference model.
module tb_psum_reader;
    import psum_reader_pkg::*;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [BW_PSUM*COL-1:0] psum_in;
    logic                   psum_valid;
    logic                   psum_full;
    logic [BW_PSUM-1:0]     rd_data;
    logic [COL_W-1:0]       rd_col;
    logic                   rd_last;
    logic                   rd_valid;
    logic                   rd_ready;
    logic [15:0]            row_cnt;
    logic                   overflow;

    int tests = 0;
    int fails = 0;

    psum_row_t   mq [$];
    int          mcol;
    logic [15:0] mcnt;
    bit          movf;

    always #5 clk = ~clk;

    psum_reader dut (
        .clk        (clk),
        .reset      (reset),
        .psum_in    (psum_in),
        .psum_valid (psum_valid),
        .psum_full  (psum_full),
        .rd_data    (rd_data),
        .rd_col     (rd_col),
        .rd_last    (rd_last),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .row_cnt    (row_cnt),
        .overflow   (overflow)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    function automatic psum_row_t inc_row();
        psum_row_t r;
        for (int c = 0; c < COL; c++) begin
            r[c*BW_PSUM +: BW_PSUM] = BW_PSUM'(c + 1);
        end
        return r;
    endfunction

    function automatic psum_row_t rand_row();
        psum_row_t r;
        for (int c = 0; c < COL; c++) begin
            r[c*BW_PSUM +: BW_PSUM] = BW_PSUM'($urandom);
        end
        return r;
    endfunction

    // Reference: a bounded queue of rows plus a column cursor.
    task automatic model_edge();
        bit do_push;
        bit do_xfer;
        if (reset) begin
            mq.delete();
            mcol = 0;
            mcnt = '0;
            movf = 1'b0;
            return;
        end
        do_push = psum_valid && (mq.size() < DEPTH);
        do_xfer = (mq.size() > 0) && rd_ready;
        if (psum_valid && mq.size() == DEPTH) movf = 1'b1;
        if (do_xfer) begin
            if (mcol == COL - 1) begin
                mcol = 0;
                void'(mq.pop_front());
                mcnt = mcnt + 16'd1;
            end else begin
                mcol = mcol + 1;
            end
        end
        if (do_push) mq.push_back(psum_in);
    endtask

    task automatic check_all();
        bit v;
        logic [BW_PSUM-1:0] w;
        v = (mq.size() > 0);
        w = '0;
        if (v) w = mq[0][mcol*BW_PSUM +: BW_PSUM];
        check("rd_valid", 32'(rd_valid), 32'(v));
        check("rd_data", 32'(rd_data), 32'(w));
        check("rd_col", 32'(rd_col), 32'(mcol));
        check("rd_last", 32'(rd_last), 32'(v && mcol == COL - 1));
        check("psum_full", 32'(psum_full), 32'(mq.size() == DEPTH));
        check("row_cnt", 32'(row_cnt), 32'(mcnt));
        check("overflow", 32'(overflow), 32'(movf));
    endtask

    task automatic cyc(input logic v, input psum_row_t row,
                       input logic rdy, input logic rst);
        psum_valid = v;
        psum_in    = row;
        rd_ready   = rdy;
        reset      = rst;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    initial begin
        psum_valid = 1'b0;
        psum_in    = '0;
        rd_ready   = 1'b0;
        reset      = 1'b1;
        mcol       = 0;
        mcnt       = '0;
        movf       = 1'b0;
        @(negedge clk);

        // reset state
        cyc(1'b0, '0, 1'b0, 1'b1);
        check("rst_row_cnt", 32'(row_cnt), 32'd0);
        check("rst_valid", 32'(rd_valid), 32'd0);

        // incrementing row, streamed with ready high
        cyc(1'b1, inc_row(), 1'b1, 1'b0);
        check("inc_first", 32'(rd_data), 32'd1);
        for (int i = 0; i < COL; i++) cyc(1'b0, '0, 1'b1, 1'b0);
        check("inc_cnt", 32'(row_cnt), 32'd1);
        check("inc_idle", 32'(rd_valid), 32'd0);

        // all -1 row passes through unchanged
        cyc(1'b1, '1, 1'b1, 1'b0);
        check("neg_word", 32'(rd_data), 32'hFFFFF);
        for (int i = 0; i < COL; i++) cyc(1'b0, '0, 1'b1, 1'b0);

        // backpressure at column 3
        cyc(1'b1, rand_row(), 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b0, 1'b0);
        check("bp_col", 32'(rd_col), 32'd3);
        for (int i = 0; i < 5; i++) cyc(1'b0, '0, 1'b1, 1'b0);

        // overflow: five pushes into a four-deep FIFO
        for (int i = 0; i < 5; i++) cyc(1'b1, rand_row(), 1'b0, 1'b0);
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_full", 32'(psum_full), 32'd1);
        for (int i = 0; i < 4 * COL + 2; i++) cyc(1'b0, '0, 1'b1, 1'b0);
        check("ovf_cnt", 32'(row_cnt), 32'd7);

        // push on the last-column transfer with two rows buffered
        cyc(1'b1, rand_row(), 1'b0, 1'b0);
        cyc(1'b1, rand_row(), 1'b0, 1'b0);
        for (int i = 0; i < COL - 1; i++) cyc(1'b0, '0, 1'b1, 1'b0);
        cyc(1'b1, rand_row(), 1'b1, 1'b0);
        check("sim_col0", 32'(rd_col), 32'd0);
        check("sim_valid", 32'(rd_valid), 32'd1);
        for (int i = 0; i < 2 * COL + 1; i++) cyc(1'b0, '0, 1'b1, 1'b0);

        // reset mid-row at column 5 with two rows buffered
        cyc(1'b1, rand_row(), 1'b0, 1'b0);
        cyc(1'b1, rand_row(), 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b0, '0, 1'b1, 1'b0);
        check("mid_col", 32'(rd_col), 32'd5);
        cyc(1'b1, rand_row(), 1'b1, 1'b1);
        check("mid_valid", 32'(rd_valid), 32'd0);
        check("mid_cnt", 32'(row_cnt), 32'd0);
        cyc(1'b1, inc_row(), 1'b1, 1'b0);
        check("mid_restart", 32'(rd_data), 32'd1);
        for (int i = 0; i < COL + 1; i++) cyc(1'b0, '0, 1'b1, 1'b0);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            cyc(1'($urandom_range(0, 1)), rand_row(),
                1'($urandom_range(0, 3) != 0),
                1'($urandom_range(0, 299) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/psum_reader.md
Name: psum_reader

Overview:
- Consumer end of the core's partial-sum output bus.
- Captures full output rows (col psums of bw_psum bits each) whenever the core strobes them valid, and buffers them in a small row FIFO.
- Streams the buffered rows one column word at a time over a valid/ready interface to downstream logic (normalizer, host readback).
- Sits beside the fullchip top and is fed from its out bus.

Parameters:
- col, 8, number of psum columns per row.
- bw, 8, activation/weight bit width.
- bw_psum, 2*bw+4 (20), width of one psum word.
- depth, 4, row FIFO depth in rows; must be a power of 2, minimum 2.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- psum_in  in  bw_psum*col  one psum row; column c occupies bits [c*bw_psum +: bw_psum], column 0 in the LSBs.
- psum_valid  in  1  psum_in holds a valid row this cycle.
- psum_full  out  1  row FIFO full; a row presented now is dropped.
- rd_data  out  bw_psum  current column word (two's complement, passed unchanged).
- rd_col  out  $clog2(col)  column index of rd_data.
- rd_last  out  1  rd_data is the last column (col-1) of its row.
- rd_valid  out  1  rd_data, rd_col and rd_last are valid.
- rd_ready  in  1  downstream accepts the word this cycle.
- row_cnt  out  16  count of rows fully streamed out; wraps modulo 2^16.
- overflow  out  1  sticky flag: a valid row arrived while full.

Behaviour:
- Reset values (synchronous, takes effect at the first rising edge with reset=1):
  - All FIFO pointers and the FIFO count = 0; col_idx = 0.
  - row_cnt = 0, overflow = 0, psum_full = 0, rd_valid = 0, rd_last = 0, rd_col = 0.
  - rd_data = 0 while rd_valid = 0.
- Reset mid-operation: buffered rows and any partially streamed row are discarded; no word is emitted on the reset cycle.
- Write side:
  - Push when psum_valid=1 and count<depth, using the pre-edge count.
  - If psum_valid=1 and count==depth, the row is dropped and overflow is set; it stays set until reset.
  - A pop in the same cycle does not make room for a push in that cycle.
- psum_full = (count==depth), registered state.
- Read FSM states:
  - IDLE: count==0, rd_valid=0.
  - STREAM: count>0, rd_valid=1, rd_data = head_row[col_idx*bw_psum +: bw_psum], rd_col = col_idx, rd_last = (col_idx==col-1).
- Transfer occurs when rd_valid & rd_ready.
  - If col_idx<col-1: col_idx increments.
  - If col_idx==col-1: col_idx returns to 0, the head row is popped, and row_cnt increments.
- Outputs are held stable while rd_valid=1 and rd_ready=0.
- Transitions:
  - IDLE->STREAM on the edge after the first push.
  - STREAM->IDLE on the last-column transfer when count becomes 0.
  - STREAM stays in STREAM with col_idx=0 if more rows remain.
- Latency: a row pushed at edge N gives rd_valid=1 with column 0 after edge N (visible in cycle N+1).
- Throughput: with rd_ready held at 1, one row streams out in col cycles.
- Simultaneous push and pop when not full: both happen and the count is unchanged.
- Pointers wrap modulo depth. row_cnt wraps from 65535 to 0 with no flag.

Decomposition:
- Shared package holds:
  - constants COL, BW, BW_PSUM and derived COL_W = $clog2(COL);
  - typedef psum_word_t (logic [BW_PSUM-1:0]);
  - typedef psum_row_t (logic [BW_PSUM*COL-1:0]).
- One natural sub-module: psum_row_fifo. It holds the depth × row storage, pointers and count, and exposes push, pop, full, empty and head.
- The serializer FSM and the counters live in psum_reader.

Test Plan:
- Reset, then push row with column c = c+1 (1..8), rd_ready=1 → rd_valid rises the cycle after the push; rd_data = 1,2,...,8 on consecutive cycles; rd_col = 0..7; rd_last only with 8; row_cnt = 1; then IDLE.
- Negative values: push a row of all 20'hFFFFF (-1) → eight words of 20'hFFFFF, no sign change.
- Backpressure: rd_ready=0 for 3 cycles mid-row at col_idx=3 → rd_data and rd_col held at column 3; no skipped or repeated columns after rd_ready returns.
- Overflow: rd_ready=0, push 5 rows (depth=4) → psum_full=1 after 4 pushes, overflow=1 on the 5th; draining yields exactly rows 1..4 in order; row_cnt = 4.
- Simultaneous push/pop at count=2: push a row on the last-column transfer → count stays 2 and the next row streams with no idle cycle.
- Reset mid-row at col_idx=5 with 2 rows buffered → next cycle rd_valid=0, row_cnt=0, overflow=0; a new push streams from column 0.
